// File: rtl/pipelined_addsub_if.sv
// pipelined_addsub_if: operand/result handshake bundle for pipelined_addsub
interface pipelined_addsub_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;
   modport master (
      output in_valid, A, B, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout, ovf
   );
   modport slave (
      input  in_valid, A, B, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout, ovf
   );
endinterface

// File: rtl/pipelined_addsub.sv
// pipelined_addsub: valid/ready adder-subtractor rippling one WIDTH/STAGES slice per pipeline stage
module pipelined_addsub #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input logic               clk,
   input logic               rst,
   pipelined_addsub_if.slave io
);
   localparam int SLICE = WIDTH / STAGES;
   if (WIDTH % STAGES != 0) begin : g_bad_cfg
      $error("pipelined_addsub: WIDTH (%0d) must be a multiple of STAGES (%0d)", WIDTH, STAGES);
   end
   logic             en;
   logic             v_q [STAGES];
   logic             v_d [STAGES];
   logic             c_q [STAGES];
   logic             c_d [STAGES];
   logic [WIDTH-1:0] a_q [STAGES];
   logic [WIDTH-1:0] a_d [STAGES];
   logic [WIDTH-1:0] b_q [STAGES];
   logic [WIDTH-1:0] b_d [STAGES];
   logic [WIDTH-1:0] s_q [STAGES];
   logic [WIDTH-1:0] s_d [STAGES];
   logic             vi  [STAGES];
   logic             ci  [STAGES];
   logic [WIDTH-1:0] ai  [STAGES];
   logic [WIDTH-1:0] bi  [STAGES];
   logic [WIDTH-1:0] si  [STAGES];
   logic [SLICE:0]   part [STAGES];
   assign en           = !v_q[STAGES-1] || io.out_ready;
   assign io.in_ready  = en;
   assign io.out_valid = v_q[STAGES-1];
   assign io.sum       = s_q[STAGES-1];
   assign io.cout      = c_q[STAGES-1];
   assign io.ovf       = (a_q[STAGES-1][WIDTH-1] == b_q[STAGES-1][WIDTH-1]) &&
                         (s_q[STAGES-1][WIDTH-1] != a_q[STAGES-1][WIDTH-1]);
   // stage k adds slice k of the skewed operands plus the carry from stage k-1; data only loads on a valid advance
   always_comb begin
      vi[0] = io.in_valid;
      ai[0] = io.A;
      bi[0] = io.sub ? ~io.B : io.B;
      ci[0] = io.sub ? 1'b1 : io.cin;
      si[0] = '0;
      for (int k = 1; k < STAGES; k++) begin
         vi[k] = v_q[k-1];
         ai[k] = a_q[k-1];
         bi[k] = b_q[k-1];
         ci[k] = c_q[k-1];
         si[k] = s_q[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
         part[k] = {1'b0, ai[k][k*SLICE +: SLICE]} + {1'b0, bi[k][k*SLICE +: SLICE]} + {{SLICE{1'b0}}, ci[k]};
         v_d[k]  = en ? vi[k] : v_q[k];
         a_d[k]  = a_q[k];
         b_d[k]  = b_q[k];
         c_d[k]  = c_q[k];
         s_d[k]  = s_q[k];
         if (en && vi[k]) begin
            a_d[k] = ai[k];
            b_d[k] = bi[k];
            c_d[k] = part[k][SLICE];
            s_d[k] = si[k];
            s_d[k][k*SLICE +: SLICE] = part[k][SLICE-1:0];
         end
      end
   end
   // stage registers; reset discards every in-flight transaction and zeroes the result
   always_ff @(posedge clk) begin
      for (int k = 0; k < STAGES; k++) begin
         v_q[k] <= rst ? 1'b0 : v_d[k];
         c_q[k] <= rst ? 1'b0 : c_d[k];
         a_q[k] <= rst ? '0 : a_d[k];
         b_q[k] <= rst ? '0 : b_d[k];
         s_q[k] <= rst ? '0 : s_d[k];
      end
   end
endmodule

// File: doc/pipelined_addsub.md
PIPELINED_ADDSUB -- requirements
Module: pipelined_addsub

Interface
REQ-001 Parameter WIDTH, default 16: operand and result width in bits.
REQ-002 Parameter STAGES, default 4: pipeline depth; WIDTH SHALL be an integer multiple of STAGES (SLICE = WIDTH/STAGES); violation SHALL be flagged at elaboration.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  operand set valid this cycle.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 A  input  WIDTH  operand A.
REQ-008 B  input  WIDTH  operand B.
REQ-009 cin  input  1  carry-in (add mode only).
REQ-010 sub  input  1  mode: 0 = add, 1 = subtract.
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  downstream accepts result.
REQ-013 sum  output  WIDTH  result.
REQ-014 cout  output  1  carry-out (add) / not-borrow (sub).
REQ-015 ovf  output  1  two's-complement signed overflow.

Function
REQ-016 Transfer in = in_valid && in_ready; transfer out = out_valid && out_ready.
REQ-017 Pipeline advance enable en = !out_valid || out_ready; in_ready SHALL equal en (combinational from out_ready and out_valid).
REQ-018 When en = 0, all stage registers, valid bits and outputs SHALL hold unchanged.
REQ-019 Add mode: result = A + B + cin, (WIDTH+1)-bit, {cout, sum}.
REQ-020 Sub mode: result = A + ~B + 1; cin ignored; cout = 1 iff A >= B unsigned.
REQ-021 ovf = (opA[MSB] == opB'[MSB]) && (sum[MSB] != opA[MSB]), opB' = B (add) or ~B (sub).
REQ-022 Stage k (0..STAGES-1) SHALL add slice k (bits k*SLICE .. k*SLICE+SLICE-1) with the carry registered from stage k-1 (stage 0 uses effective carry-in); no stage SHALL contain a carry chain longer than SLICE bits.
REQ-023 Upper operand slices SHALL be delayed (skewed) and completed lower sum slices carried forward so all slices of one transaction emerge together.
REQ-024 Latency: operands accepted at edge N with no stall SHALL appear on out_valid/sum/cout/ovf after edge N+STAGES-1... precisely: out_valid high in cycle N+STAGES (STAGES register stages).
REQ-025 Throughput: one transaction per cycle when out_ready held high; back-to-back acceptance with no bubbles.
REQ-026 Each stage SHALL carry a valid bit; bubbles (in_valid = 0 while en = 1) SHALL propagate as invalid stages and SHALL not produce out_valid.
REQ-027 Results SHALL leave in acceptance order; no transaction lost or duplicated under any out_ready pattern.
REQ-028 sum, cout, ovf SHALL remain stable while out_valid = 1 and out_ready = 0.
REQ-029 STAGES = 1 SHALL degenerate to a single registered WIDTH-bit adder with identical handshake.

Reset
REQ-030 rst sampled high at a rising edge SHALL clear all valid bits, out_valid = 0, sum = 0, cout = 0, ovf = 0; in_ready = 1 in the following cycle.
REQ-031 rst SHALL take priority over in_valid/out_ready in the same cycle; in-flight transactions SHALL be discarded, never emitted.

Verification (WIDTH=16, STAGES=4 unless stated)
REQ-032 Reset: rst high 2 cycles -> out_valid=0, sum=0000, cout=0, ovf=0, in_ready=1.
REQ-033 Add carry ripple across all slices: A=FFFF B=0001 cin=0 sub=0 -> 4 cycles later sum=0000 cout=1 ovf=0.
REQ-034 Signed overflow: A=7FFF B=0001 sub=0 -> sum=8000 cout=0 ovf=1; A=8000 B=0001 sub=1 -> sum=7FFF cout=1 ovf=1.
REQ-035 Subtract with borrow: A=0003 B=0005 sub=1 cin=1 -> sum=FFFE cout=0 ovf=0 (cin ignored).
REQ-036 Backpressure: 8 back-to-back random ops, out_ready low cycles 3..6 -> in_ready low while stalled, outputs stable, all 8 results correct and in order vs. reference model.
REQ-037 Reset mid-flight: 3 ops accepted, rst high 1 cycle -> out_valid=0 next cycle, none of the 3 ever emitted; new op after reset completes with latency 4; repeat sweep with STAGES=1 and WIDTH=32/STAGES=8.
